// File: rtl/lzw_pkg.sv
// ---------------------------------------------------------------------------
// lzw_pkg
// Shared types and constants for the LZW input path.
//   BYTE_W          width of one LZW input symbol
//   byte_t          one LZW input symbol
//   stream_state_e  states of the file streaming engine
// ---------------------------------------------------------------------------
package lzw_pkg;

  localparam int BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } stream_state_e;

endpackage

// File: rtl/stream_skid_buf.sv
// ---------------------------------------------------------------------------
// stream_skid_buf
// Two-entry output buffer between the memory read port and the consumer.
// out_data/out_last always come straight from the head register, so they
// stay stable while the consumer stalls.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 drop all entries (takes priority over push/pop)
//   in_valid / in_ready   write side; in_ready is low only when both entries full
//   in_data / in_last     word and last-beat marker to store
//   out_valid / out_ready read side handshake
//   out_data / out_last   head entry
//   count                 number of occupied entries (0..2)
// ---------------------------------------------------------------------------
module stream_skid_buf
  import lzw_pkg::*;
#(
  parameter int DATA_WIDTH = BYTE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] tail_data;
  logic                  tail_last;
  logic [1:0]            count_next;
  logic                  push;
  logic                  pop;

  assign in_ready = (count != 2'd2);
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

  // Occupancy update; a flush empties the buffer regardless of traffic.
  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = 2'd0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + 2'd1;
        2'b01:   count_next = count - 2'd1;
        default: count_next = count;
      endcase
    end
  end

  // Entry storage: the head only changes when it is empty or being popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= 2'd0;
      out_valid <= 1'b0;
      out_data  <= {DATA_WIDTH{1'b0}};
      out_last  <= 1'b0;
      tail_data <= {DATA_WIDTH{1'b0}};
      tail_last <= 1'b0;
    end else begin
      count     <= count_next;
      out_valid <= (count_next != 2'd0);
      if (!flush) begin
        if (pop) begin
          if (count == 2'd2) begin
            // in_ready is low when full, so no push can coincide here
            out_data <= tail_data;
            out_last <= tail_last;
          end else if (push) begin
            out_data <= in_data;
            out_last <= in_last;
          end
        end else if (push) begin
          if (count == 2'd0) begin
            out_data <= in_data;
            out_last <= in_last;
          end else begin
            tail_data <= in_data;
            tail_last <= in_last;
          end
        end
      end
    end
  end

endmodule

// File: rtl/file_stream_rom.sv
// ---------------------------------------------------------------------------
// file_stream_rom
// Loadable on-chip file image that streams `length` words to the LZW
// compressor over a valid/ready interface with a last-beat marker.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   load_en/addr/data      memory write port, ignored while busy
//   len_wr, len_in         set stream length (saturated to DEPTH), ignored while busy
//   start                  rewind to word 0 and stream; ignored while busy
//   abort                  stop, flush buffer, back to idle (beats start)
//   out_valid/ready/data/last  stream output
//   eof                    sticky, set once the last beat is taken
//   busy                   engine is not idle
// ---------------------------------------------------------------------------
module file_stream_rom
  import lzw_pkg::*;
#(
  parameter int    DATA_WIDTH  = BYTE_W,
  parameter int    DEPTH       = 4096,
  parameter int    ADDR_WIDTH  = 12,
  parameter int    DEFAULT_LEN = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  len_wr,
  input  logic [ADDR_WIDTH:0]   len_in,
  input  logic                  start,
  input  logic                  abort,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  eof,
  output logic                  busy
);

  localparam int               AW1       = ADDR_WIDTH + 1;
  localparam logic [1:0]       ST_IDLE   = IDLE;
  localparam logic [1:0]       ST_STREAM = STREAM;
  localparam logic [1:0]       ST_DRAIN  = DRAIN;
  localparam logic [ADDR_WIDTH:0] PTR_ZERO  = AW1'(0);
  localparam logic [ADDR_WIDTH:0] PTR_ONE   = AW1'(1);
  localparam logic [ADDR_WIDTH:0] DEPTH_LEN = AW1'(DEPTH);
  localparam logic [ADDR_WIDTH:0] RESET_LEN = AW1'(DEFAULT_LEN);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [1:0]            state;
  logic [1:0]            state_next;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr_next;
  logic [ADDR_WIDTH:0]   length;
  logic                  eof_next;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_is_last;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_last;
  logic                  inflight;
  logic                  pop;
  logic [1:0]            buf_count;
  logic                  buf_in_ready;
  logic                  room;

  assign pop = out_valid & out_ready;
  // A new read must still fit once the in-flight word lands, counting the
  // slot freed by a beat leaving this cycle.
  assign room = (({1'b0, buf_count} + {2'b00, inflight}) < ({2'b00, pop} + 3'd2));

  // Block RAM: load port plus synchronous stream read (never both at once).
  always_ff @(posedge clk) begin
    if (load_en && !busy) begin
      mem[load_addr] <= load_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

  // Next-state, read issue and eof decisions.
  always_comb begin
    state_next  = state;
    rd_ptr_next = rd_ptr;
    eof_next    = eof;
    rd_en       = 1'b0;
    rd_addr     = rd_ptr[ADDR_WIDTH-1:0];
    rd_is_last  = 1'b0;
    if (abort) begin
      state_next  = ST_IDLE;
      rd_ptr_next = PTR_ZERO;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (length == PTR_ZERO) begin
              eof_next = 1'b1;
            end else begin
              // word 0 is read on the start edge so the first beat shows up
              // two cycles after start
              eof_next    = 1'b0;
              rd_en       = 1'b1;
              rd_addr     = {ADDR_WIDTH{1'b0}};
              rd_is_last  = (length == PTR_ONE);
              rd_ptr_next = PTR_ONE;
              state_next  = (length == PTR_ONE) ? ST_DRAIN : ST_STREAM;
            end
          end else begin
            state_next = ST_IDLE;
          end
        end
        ST_STREAM: begin
          if ((rd_ptr < length) && room) begin
            rd_en       = 1'b1;
            rd_is_last  = ((rd_ptr + PTR_ONE) == length);
            rd_ptr_next = rd_ptr + PTR_ONE;
            state_next  = ((rd_ptr + PTR_ONE) == length) ? ST_DRAIN : ST_STREAM;
          end else begin
            state_next = ST_STREAM;
          end
        end
        ST_DRAIN: begin
          if (pop && out_last) begin
            state_next = ST_IDLE;
            eof_next   = 1'b1;
          end else begin
            state_next = ST_DRAIN;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rd_ptr   <= PTR_ZERO;
      length   <= RESET_LEN;
      eof      <= 1'b0;
      busy     <= 1'b0;
      inflight <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      state    <= state_next;
      rd_ptr   <= rd_ptr_next;
      eof      <= eof_next;
      busy     <= (state_next != ST_IDLE);
      // abort never issues, so any outstanding read is dropped here
      inflight <= rd_en;
      if (rd_en) begin
        rd_last <= rd_is_last;
      end
      if (len_wr && !busy) begin
        length <= (len_in > DEPTH_LEN) ? DEPTH_LEN : len_in;
      end
    end
  end

  stream_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (abort),
    .in_valid (inflight),
    .in_ready (buf_in_ready),
    .in_data  (rd_data),
    .in_last  (rd_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .count    (buf_count)
  );

endmodule

// File: tb/tb_file_stream_rom.sv
// ---------------------------------------------------------------------------
// tb_file_stream_rom
// Self-checking bench for file_stream_rom (DEPTH=32 instance).
// ---------------------------------------------------------------------------
module tb_file_stream_rom;

  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [7:0]    load_data;
  logic          len_wr;
  logic [AW:0]   len_in;
  logic          start;
  logic          abort;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic          out_last;
  logic          eof;
  logic          busy;

  logic [7:0] img [DEPTH];
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       start;
    logic       abort;
    logic       ready;
    logic       ev;
    logic [7:0] ed;
    logic       el;
    logic       ee;
    logic       eb;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  file_stream_rom #(
    .DATA_WIDTH (8),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW),
    .DEFAULT_LEN(0),
    .INIT_FILE  ("")
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_en  (load_en),
    .load_addr(load_addr),
    .load_data(load_data),
    .len_wr   (len_wr),
    .len_in   (len_in),
    .start    (start),
    .abort    (abort),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .eof      (eof),
    .busy     (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_img(input int n);
    for (int i = 0; i < n; i++) begin
      load_en   = 1'b1;
      load_addr = AW'(i);
      load_data = img[i];
      tick();
    end
    load_en = 1'b0;
  endtask

  task automatic set_len(input logic [AW:0] v);
    len_wr = 1'b1;
    len_in = v;
    tick();
    len_wr = 1'b0;
  endtask

  // Start with ready held high; expect n consecutive beats from img, first one
  // two cycles after start. With hammer set, loads are attempted while busy.
  task automatic run_stream(input string tag, input int n, input logic hammer);
    int beats;
    int first_cyc;
    int last_cyc;
    beats = 0;
    first_cyc = -1;
    last_cyc = -1;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < n + 8; c++) begin
      if (hammer) begin
        load_en   = 1'b1;
        load_addr = AW'(c);
        load_data = 8'hEE;
      end
      if (out_valid) begin
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
        check($sformatf("%s.data[%0d]", tag, beats), 32'(out_data), 32'(img[beats % DEPTH]));
        check($sformatf("%s.last[%0d]", tag, beats), 32'(out_last), 32'(beats == n - 1));
        beats++;
      end
      if (beats == n) break;
      tick();
    end
    tick();
    load_en = 1'b0;
    check({tag, ".beats"}, 32'(beats), 32'(n));
    check({tag, ".latency"}, 32'(first_cyc), 32'd1);
    check({tag, ".back_to_back"}, 32'(last_cyc - first_cyc), 32'(n - 1));
    check({tag, ".eof"}, 32'(eof), 32'd1);
    check({tag, ".busy_done"}, 32'(busy), 32'd0);
    check({tag, ".valid_done"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       held;
    logic [7:0] prev_data;
    logic       prev_last;
    logic       r;
    int         idx;

    rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = 8'h00;
    len_wr = 1'b0; len_in = '0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.data",  32'(out_data),  32'd0);
    check("rst.last",  32'(out_last),  32'd0);
    check("rst.eof",   32'(eof),       32'd0);
    check("rst.busy",  32'(busy),      32'd0);
    rst_n = 1'b1;
    tick();

    // "ABBABBBABBA"
    img[0] = 8'h41; img[1] = 8'h42; img[2] = 8'h42; img[3]  = 8'h41;
    img[4] = 8'h42; img[5] = 8'h42; img[6] = 8'h42; img[7]  = 8'h41;
    img[8] = 8'h42; img[9] = 8'h42; img[10] = 8'h41;
    load_img(11);
    set_len(6'd11);

    // Cycle table: {start, abort, ready, exp valid, data, last, eof, busy}
    // rows 0-13: full stream; 14-21: abort after beat 5; 22-24: replay then abort
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h42, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h42, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h42, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h42, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h42, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h42, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h42, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h41, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h42, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h42, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h42, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].start;
      abort = vecs[i].abort;
      out_ready = vecs[i].ready;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check($sformatf("vec%0d.valid", i), 32'(out_valid), 32'(vecs[i].ev));
      check($sformatf("vec%0d.eof", i),   32'(eof),       32'(vecs[i].ee));
      check($sformatf("vec%0d.busy", i),  32'(busy),      32'(vecs[i].eb));
      if (vecs[i].ev) begin
        check($sformatf("vec%0d.data", i), 32'(out_data), 32'(vecs[i].ed));
        check($sformatf("vec%0d.last", i), 32'(out_last), 32'(vecs[i].el));
      end
    end

    // Zero length: eof one cycle after start, never busy, never valid.
    set_len(6'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("len0.eof",   32'(eof),       32'd1);
    check("len0.busy",  32'(busy),      32'd0);
    check("len0.valid", 32'(out_valid), 32'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("len0.busy%0d", c),  32'(busy),      32'd0);
      check($sformatf("len0.valid%0d", c), 32'(out_valid), 32'd0);
    end

    // Random back-pressure: same 11 words, in order, stable while stalled.
    set_len(6'd11);
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("bp.eof_cleared", 32'(eof), 32'd0);
    idx = 0;
    held = 1'b0;
    prev_data = 8'h00;
    prev_last = 1'b0;
    for (int c = 0; c < 200 && idx < 11; c++) begin
      if (held) begin
        check($sformatf("bp.stable%0d", c), {22'd0, out_valid, out_last, out_data},
              {22'd0, 1'b1, prev_last, prev_data});
      end
      r = 1'($urandom_range(0, 1));
      out_ready = r;
      if (out_valid && r) begin
        check($sformatf("bp.data[%0d]", idx), 32'(out_data), 32'(img[idx]));
        check($sformatf("bp.last[%0d]", idx), 32'(out_last), 32'(idx == 10));
        idx++;
        held = 1'b0;
      end else if (out_valid) begin
        held = 1'b1;
        prev_data = out_data;
        prev_last = out_last;
      end else begin
        held = 1'b0;
      end
      tick();
    end
    check("bp.beats", 32'(idx), 32'd11);
    check("bp.eof", 32'(eof), 32'd1);
    out_ready = 1'b1;
    tick();
    tick();
    check("bp.no_extra", 32'(out_valid), 32'd0);

    // Reset mid-stream, then replay.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mrst.valid", 32'(out_valid), 32'd0);
    check("mrst.data",  32'(out_data),  32'd0);
    check("mrst.last",  32'(out_last),  32'd0);
    check("mrst.eof",   32'(eof),       32'd0);
    check("mrst.busy",  32'(busy),      32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    // length came back as DEFAULT_LEN (0)
    start = 1'b1;
    tick();
    start = 1'b0;
    check("mrst.len_default_eof",  32'(eof),  32'd1);
    check("mrst.len_default_busy", 32'(busy), 32'd0);
    set_len(6'd11);
    run_stream("replay", 11, 1'b0);

    // Full image, oversized length saturates; loads while busy are ignored.
    for (int i = 0; i < DEPTH; i++) img[i] = 8'((i * 7) + 3);
    load_img(DEPTH);
    set_len(6'(DEPTH + 5));
    run_stream("full", DEPTH, 1'b1);
    run_stream("full_again", DEPTH, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
